// File: rtl/flow_key_extractor_if.sv
// flow_key_extractor_if: AXI4-Stream beat signals shared by a stream source and a snooping sink
interface flow_key_extractor_if;
    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tready, tlast);
    modport slave  (input  tdata, tvalid, tready, tlast);
endinterface

// File: rtl/flow_key_extractor.sv
// flow_key_extractor: snoops an Ethernet stream and emits an IPv4 5-tuple flow key per eligible packet
module flow_key_extractor (
    input  logic                       clk,
    input  logic                       rst_n,
    flow_key_extractor_if.slave        s_axis,
    output logic [127:0]               flow_key,
    output logic                       flow_key_valid,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                key_cnt,
    output logic [31:0]                skip_cnt
);
    typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_B4, S_DRAIN} state_t;

    state_t         r_state;
    logic [7:0]     r_proto;
    logic           r_l4_ok;
    logic [31:0]    r_src_ip;
    logic [15:0]    r_dst_hi;
    logic           r_key_sent;
    logic [127:0]   r_flow_key;
    logic           r_key_valid;
    logic [31:0]    r_pkt_cnt;
    logic [31:0]    r_key_cnt;
    logic [31:0]    r_skip_cnt;

    logic [63:0]    w_d;
    logic           w_beat;
    logic           w_last;
    logic           w_ipv4;
    logic           w_emit;
    logic           w_skip;

    // Lane k of the beat carries byte k of the 8-byte group; fields are big-endian across lanes
    assign w_d    = s_axis.tdata;
    assign w_beat = s_axis.tvalid && s_axis.tready;
    assign w_last = w_beat && s_axis.tlast;
    assign w_ipv4 = ({w_d[39:32], w_d[47:40]} == 16'h0800) && (w_d[55:48] == 8'h45);
    assign w_emit = w_beat && (r_state == S_B4);
    assign w_skip = w_last && !w_emit && !r_key_sent;

    assign flow_key       = r_flow_key;
    assign flow_key_valid = r_key_valid;
    assign pkt_cnt        = r_pkt_cnt;
    assign key_cnt        = r_key_cnt;
    assign skip_cnt       = r_skip_cnt;

    // Header walk: capture fields beat by beat and register the key on the S_B4 beat; tlast always restarts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_B0;
            r_proto     <= '0;
            r_l4_ok     <= 1'b0;
            r_src_ip    <= '0;
            r_dst_hi    <= '0;
            r_key_sent  <= 1'b0;
            r_flow_key  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_beat) begin
                case (r_state)
                    S_B0: r_state <= S_B1;
                    S_B1: r_state <= w_ipv4 ? S_B2 : S_DRAIN;
                    S_B2: begin
                        r_proto <= w_d[63:56];
                        r_l4_ok <= (w_d[63:56] == 8'd6 || w_d[63:56] == 8'd17) &&
                                   ({w_d[36:32], w_d[47:40]} == 13'd0);
                        r_state <= S_B3;
                    end
                    S_B3: begin
                        r_src_ip <= {w_d[23:16], w_d[31:24], w_d[39:32], w_d[47:40]};
                        r_dst_hi <= {w_d[55:48], w_d[63:56]};
                        r_state  <= S_B4;
                    end
                    S_B4: begin
                        r_flow_key  <= {24'h0, r_proto,
                                        r_l4_ok ? {w_d[39:32], w_d[47:40]} : 16'h0,
                                        r_l4_ok ? {w_d[23:16], w_d[31:24]} : 16'h0,
                                        r_dst_hi, w_d[7:0], w_d[15:8], r_src_ip};
                        r_key_valid <= 1'b1;
                        r_key_sent  <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                    default: r_state <= S_DRAIN;
                endcase
                if (s_axis.tlast) begin
                    r_state    <= S_B0;
                    r_key_sent <= 1'b0;
                end
            end
        end
    end

    // Statistics counters; each advances independently so coincident events are never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_key_cnt  <= '0;
            r_skip_cnt <= '0;
        end else begin
            r_pkt_cnt  <= r_pkt_cnt  + {31'd0, w_last};
            r_key_cnt  <= r_key_cnt  + {31'd0, w_emit};
            r_skip_cnt <= r_skip_cnt + {31'd0, w_skip};
        end
    end
endmodule

// File: tb/tb_flow_key_extractor.sv
// tb_flow_key_extractor: table-driven packet vectors with a key scoreboard for flow_key_extractor
module tb_flow_key_extractor;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] flow_key;
    logic         flow_key_valid;
    logic [31:0]  pkt_cnt, key_cnt, skip_cnt;

    flow_key_extractor_if s_if ();

    flow_key_extractor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (s_if),
        .flow_key       (flow_key),
        .flow_key_valid (flow_key_valid),
        .pkt_cnt        (pkt_cnt),
        .key_cnt        (key_cnt),
        .skip_cnt       (skip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  eth;
        logic [7:0]   b14;
        logic [7:0]   proto;
        logic [15:0]  frag;
        logic [31:0]  src;
        logic [31:0]  dst;
        logic [15:0]  sp;
        logic [15:0]  dp;
        int           nb;
        bit           stall;
        bit           emit;
        logic [127:0] key;
    } vec_t;

    typedef struct {
        logic [127:0] key;
        int           cyc;
    } exp_t;

    vec_t         v [13];
    exp_t         sb [$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    int           prev_strobe = 0;
    int           last_gap = 0;
    logic [127:0] prev_key = '0;
    int           exp_pkt = 0, exp_key = 0, exp_skip = 0;

    localparam logic [127:0] K1 = 128'h000000_11_0050_04D2_0A000002_0A000001;
    localparam logic [127:0] K2 = 128'h000000_01_0000_0000_0A000002_0A000001;
    localparam logic [127:0] K3 = 128'h000000_11_0000_0000_0A000002_0A000001;
    localparam logic [127:0] K4 = 128'h000000_06_01BB_1F90_AC100005_C0A8010A;
    localparam logic [127:0] K5 = 128'h000000_06_0016_ABCD_05060708_01020304;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Strobe monitor: pops the scoreboard on every strobe and checks the key is held otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_key = flow_key;
        end else begin
            if (flow_key_valid) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe: unexpected key %h at cycle %0d, required no strobe", flow_key, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (flow_key !== e.key || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL key: got %h at cycle %0d, required %h at cycle %0d", flow_key, cyc, e.key, e.cyc);
                    end
                end
                last_gap    = cyc - prev_strobe;
                prev_strobe = cyc;
            end else begin
                n_vec++;
                if (flow_key !== prev_key) begin
                    n_err++;
                    $display("FAIL hold: key changed to %h without strobe, required %h", flow_key, prev_key);
                end
            end
            prev_key = flow_key;
        end
    end

    task automatic beat(input logic [63:0] d, input logic last);
        @(posedge clk); #1;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tready = 1'b1;
        s_if.tlast  = last;
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        s_if.tdata  = {$urandom, $urandom};
        s_if.tvalid = k[0];
        s_if.tready = !k[0];
        s_if.tlast  = 1'b1;
    endtask

    task automatic send_pkt(input vec_t p);
        logic [7:0]  b [64];
        logic [63:0] d;
        foreach (b[k]) b[k] = 8'($urandom);
        {b[12], b[13]} = p.eth;
        b[14] = p.b14;
        {b[20], b[21]} = p.frag;
        b[23] = p.proto;
        {b[26], b[27], b[28], b[29]} = p.src;
        {b[30], b[31], b[32], b[33]} = p.dst;
        {b[34], b[35]} = p.sp;
        {b[36], b[37]} = p.dp;
        for (int i = 0; i < p.nb; i++) begin
            if (p.stall && i > 0) idle(i);
            for (int j = 0; j < 8; j++) d[8*j +: 8] = b[8*i + j];
            beat(d, i == p.nb - 1);
            if (i == 4 && p.emit) sb.push_back('{p.key, cyc + 1});
        end
    endtask

    task automatic check_counters(input string tag);
        repeat (3) idle(2);
        @(negedge clk);
        chk({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        chk({tag, "_key_cnt"}, key_cnt, exp_key);
        chk({tag, "_skip_cnt"}, skip_cnt, exp_skip);
        chk({tag, "_pending_keys"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        v[0]  = '{16'h0800, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 1, K1};
        v[1]  = '{16'h0800, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 1, 1, K1};
        v[2]  = '{16'h0806, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 0, '0};
        v[3]  = '{16'h0800, 8'h46, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 0, '0};
        v[4]  = '{16'h0800, 8'h45, 8'd1,  16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  6, 0, 1, K2};
        v[5]  = '{16'h0800, 8'h45, 8'd17, 16'h00B9, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 1, K3};
        v[6]  = '{16'h0800, 8'h45, 8'd17, 16'h4000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 1, K1};
        v[7]  = '{16'h8100, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  8, 0, 0, '0};
        v[8]  = '{16'h0800, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  3, 0, 0, '0};
        v[9]  = '{16'h0800, 8'h45, 8'd17, 16'h0000, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80,  4, 0, 0, '0};
        v[10] = '{16'h0800, 8'h45, 8'd6,  16'h0000, 32'hC0A8010A, 32'hAC100005, 16'h1F90, 16'h01BB, 5, 0, 1, K4};
        v[11] = '{16'h0800, 8'h45, 8'd6,  16'h0000, 32'h01020304, 32'h05060708, 16'hABCD, 16'h0016, 7, 1, 1, K5};
        v[12] = '{16'h0800, 8'h45, 8'd6,  16'h2000, 32'h01020304, 32'h05060708, 16'hABCD, 16'h0016, 5, 0, 1, K5};

        rst_n = 1'b0;
        s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tready = 1'b0; s_if.tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flow_key", flow_key, '0);
        chk("rst_valid", flow_key_valid, 1'b0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_key_cnt", key_cnt, 0);
        chk("rst_skip_cnt", skip_cnt, 0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            send_pkt(v[i]);
            exp_pkt++;
            if (v[i].emit) exp_key++; else exp_skip++;
            check_counters($sformatf("vec%0d", i));
        end

        beat(64'h0, 1'b0);
        beat(64'h0045_0008_0000_0000, 1'b0);
        beat(64'h1100_0000_0000_0000, 1'b0);
        beat(64'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flow_key", flow_key, '0);
        chk("async_rst_valid", flow_key_valid, 1'b0);
        chk("async_rst_pkt_cnt", pkt_cnt, 0);
        chk("async_rst_key_cnt", key_cnt, 0);
        chk("async_rst_skip_cnt", skip_cnt, 0);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_pkt = 0; exp_key = 0; exp_skip = 0;

        send_pkt(v[10]);
        send_pkt(v[12]);
        exp_pkt = 2; exp_key = 2;
        check_counters("b2b");
        chk("b2b_gap", 128'(last_gap), 128'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/flow_key_extractor.md
# flow_key_extractor

Header parser that sits directly upstream of the flow table. It snoops a 64-bit AXI4-Stream Ethernet packet stream without stalling it. For each eligible IPv4 packet it builds the 128-bit 5-tuple flow key and presents it with a one-cycle `flow_key_valid` strobe, which drives the flow table's `flow_key` and `flow_key_valid` inputs. It also keeps packet, key and skip counters for the PS.

## Interface
- No parameters. Data width is fixed at 64 bits and the key at 128 bits.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 64: stream data. Byte 0 (first on the wire) is `tdata[7:0]`.
- `s_axis_tvalid` in 1: stream valid.
- `s_axis_tready` in 1: stream ready, observed only. The block never drives or stalls the stream.
- `s_axis_tlast` in 1: last beat of the packet.
- `flow_key` out 128: extracted key. Held stable between emissions.
- `flow_key_valid` out 1: one-cycle strobe indicating `flow_key` is new.
- `pkt_cnt` out 32: count of packets seen, i.e. `tlast` beats.
- `key_cnt` out 32: count of keys emitted.
- `skip_cnt` out 32: count of packets that ended without a key.

## Operation
- A beat is a cycle with `tvalid && tready`. Nothing advances on other cycles.
- Multi-byte header fields are big-endian: the lower byte index is the MSB.
- Key layout:
  - [31:0] src IP, bytes 26–29.
  - [63:32] dst IP, bytes 30–33.
  - [79:64] src port, bytes 34–35.
  - [95:80] dst port, bytes 36–37.
  - [103:96] IP protocol, byte 23.
  - [127:104] zero.
- State machine states: `S_B0`, `S_B1`, `S_B2`, `S_B3`, `S_B4`, `S_DRAIN`. The state after reset is `S_B0`.
- `S_B0`: on a beat, go to `S_B1`. Bytes 0–7 (MACs) are ignored.
- `S_B1`: check ethertype (bytes 12–13) == 0x0800 and byte 14 == 0x45 (IPv4, IHL=5).
  - Pass: go to `S_B2`.
  - Fail: go to `S_DRAIN`.
  - VLAN-tagged, IPv6 and IP-options packets are therefore ineligible.
- `S_B2`: capture protocol (byte 23). Record `l4_ok` = (protocol is 6 or 17) and fragment offset (bytes 20–21, bits 12:0) == 0. Go to `S_B3`.
- `S_B3`: capture src IP (bytes 26–29) and dst IP upper half (bytes 30–31). Go to `S_B4`.
- `S_B4`: capture dst IP lower half (bytes 32–33).
  - Ports come from bytes 34–37 if `l4_ok`, otherwise both ports are 0.
  - Emit the key. Go to `S_DRAIN`.
- `S_DRAIN`: wait for the end of the packet.
- A `tlast` beat in any state sends the FSM to `S_B0`. This takes priority over the transitions listed above.
- A `tlast` on the `S_B4` beat still emits the key, since a 38-byte truncated frame is still valid for the key.
- A runt packet (`tlast` in `S_B0`..`S_B3`) produces no key.
- Counters, each wrapping at 2^32:
  - `pkt_cnt` increments on every `tlast` beat.
  - `key_cnt` increments with every `flow_key_valid`.
  - `skip_cnt` increments on a `tlast` beat for any packet that did not emit a key, covering both ineligible and runt packets.
  - Counter updates in the same cycle are independent; no update is lost.

## Timing
- Reset values: `flow_key` = 0, `flow_key_valid` = 0, all counters 0, state `S_B0`.
- Latency: `flow_key_valid` and the new `flow_key` are registered and appear in the cycle after the `S_B4` beat.
- `flow_key_valid` is high for exactly one cycle.
- A minimum eligible packet is 5 beats, so strobes are at least 5 cycles apart. The flow table needs no backpressure.
- `flow_key` changes only in the cycle its strobe is asserted.
- Counters update in the cycle after the qualifying beat. `key_cnt` updates in the same cycle as `flow_key_valid`.
- Stall cycles (`tvalid` or `tready` low) between header beats do not affect the result.
- Reset mid-packet: the FSM returns to `S_B0` asynchronously and any partial capture is discarded. The stream source shares `rst_n`, so the next beat is a packet start.

## Test plan
- UDP packet: 10.0.0.1:1234 -> 10.0.0.2:80, proto 17, 8 beats.
  - `flow_key` = 0x000000_11_0050_04D2_0A000002_0A000001 one cycle after beat 4, with a single-cycle strobe.
  - `pkt_cnt` = 1, `key_cnt` = 1.
- Same packet with `tvalid` or `tready` toggled low between every beat.
  - Identical key, exactly one strobe, emitted one cycle after the 5th accepted beat.
- Ineligible packets:
  - ARP (ethertype 0x0806): no strobe, `skip_cnt` = 1.
  - IPv4 with byte 14 = 0x46: no strobe, `skip_cnt` = 2.
- Special IPv4 cases:
  - ICMP (proto 1): key with both ports 0.
  - UDP with fragment offset 0x00B9: key with ports 0 and proto 0x11.
- Runt and short packets:
  - 3-beat packet: no strobe, `skip_cnt` +1.
  - 5-beat packet with `tlast` on beat 4: key emitted, `skip_cnt` unchanged.
  - Next packet parses correctly.
- Reset and back-to-back packets:
  - Assert `rst_n` low during beat 3 of a packet: outputs and counters return to 0 and no strobe occurs.
  - After release, back-to-back 5-beat eligible packets give strobes exactly 5 cycles apart.
